// File: rtl/dff_share_arb.sv
// Round-robin arbiter that time-shares one external enabled register between N
// requesters and presents the held word downstream with its source index.
module dff_share_arb #(
    parameter  int N  = 4,
    parameter  int DW = 32,
    localparam int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_valid,
    input  logic [N*DW-1:0] req_data,
    output logic [N-1:0]    req_ready,
    output logic            dff_en,
    output logic [DW-1:0]   dff_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IW-1:0]   out_src
);

    localparam int unsigned NU = N;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t        r_state;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_src;

    logic          w_accept;
    logic          w_found;
    logic [IW-1:0] w_gidx;
    logic          w_grant;
    logic [IW-1:0] w_ptr_next;

    // Search ptr, ptr+1, ... mod N; the first valid lane wins.
    always_comb begin
        int unsigned v_idx;
        v_idx   = 0;
        w_found = 1'b0;
        w_gidx  = '0;
        for (int unsigned k = 0; k < NU; k++) begin
            v_idx = 32'(r_ptr) + k;
            if (v_idx >= NU) begin
                v_idx = v_idx - NU;
            end
            if (!w_found && req_valid[v_idx]) begin
                w_found = 1'b1;
                w_gidx  = IW'(v_idx);
            end
        end
    end

    // Gating with rst_n keeps the grant outputs quiet while reset is held.
    assign w_accept   = (r_state == EMPTY) || out_ready;
    assign w_grant    = rst_n && w_accept && w_found;
    assign w_ptr_next = (w_gidx == IW'(N - 1)) ? '0 : w_gidx + IW'(1);

    always_comb begin
        req_ready = '0;
        dff_en    = 1'b0;
        dff_data  = '0;
        if (w_grant) begin
            req_ready = N'(1) << w_gidx;
            dff_en    = 1'b1;
            dff_data  = req_data[int'(w_gidx)*DW +: DW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_ptr   <= '0;
            r_src   <= '0;
        end else if (w_grant) begin
            r_state <= FULL;
            r_src   <= w_gidx;
            r_ptr   <= w_ptr_next;
        end else if (r_state == FULL && out_ready) begin
            r_state <= EMPTY;
        end
    end

    assign out_valid = (r_state == FULL);
    assign out_src   = r_src;

endmodule

// File: tb/tb_dff_share_arb.sv
// Directed bench for dff_share_arb (N=4, DW=32); models the shared register
// externally and checks grants, handshake, fairness order and async reset.
module tb_dff_share_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            dff_en;
    logic [DW-1:0]   dff_data;
    logic            out_valid;
    logic            out_ready;
    logic [IW-1:0]   out_src;
    logic [DW-1:0]   r_reg;

    int checks;
    int errors;

    dff_share_arb #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .dff_en    (dff_en),
        .dff_data  (dff_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The shared holding register driven by the arbiter.
    always_ff @(posedge clk) begin
        if (dff_en) r_reg <= dff_data;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] rdy, input logic [31:0] data);
        chk({tag, "_ready"}, 64'(req_ready), 64'(rdy));
        chk({tag, "_en"}, 64'(dff_en), 64'(rdy != 4'b0000));
        chk({tag, "_data"}, 64'(dff_data), 64'(data));
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] src, input logic [31:0] data);
        chk({tag, "_valid"}, 64'(out_valid), 64'(v));
        chk({tag, "_src"}, 64'(out_src), 64'(src));
        if (v) chk({tag, "_reg"}, 64'(r_reg), 64'(data));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        out_ready = 1'b0;
        req_data  = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
        #3;
        chk_out("rst", 1'b0, 2'd0, 32'h0);
        chk_grant("rst", 4'b0000, 32'h0);
        rst_n = 1'b1;
        tick();

        // Only lane 2 valid from empty.
        req_valid = 4'b0100;
        #1;
        chk_grant("l2", 4'b0100, 32'hA5A5_0002);
        tick();
        chk_out("l2", 1'b1, 2'd2, 32'hA5A5_0002);

        // Wrap: ptr=3, lanes 0 and 3 -> 3 then 0.
        req_valid = 4'b1001;
        out_ready = 1'b1;
        #1;
        chk_grant("wrap3", 4'b1000, 32'hA5A5_0003);
        tick();
        chk_out("wrap3", 1'b1, 2'd3, 32'hA5A5_0003);
        chk_grant("wrap0", 4'b0001, 32'hA5A5_0000);
        tick();
        chk_out("wrap0", 1'b1, 2'd0, 32'hA5A5_0000);

        // Drain with no requests, then out_ready while empty is ignored.
        req_valid = 4'b0000;
        #1;
        chk_grant("drain", 4'b0000, 32'h0);
        tick();
        chk("drain_valid", 64'(out_valid), 64'd0);
        tick();
        chk("empty_ordy", 64'(out_valid), 64'd0);

        // Saved ptr=1: lanes 0 and 1 valid -> lane 1 wins.
        req_valid = 4'b0011;
        #1;
        chk_grant("saved", 4'b0010, 32'hA5A5_0001);
        tick();
        chk_out("saved", 1'b1, 2'd1, 32'hA5A5_0001);

        // Hold while FULL and !out_ready.
        out_ready = 1'b0;
        req_valid = 4'b1001;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk_grant("hold", 4'b0000, 32'h0);
            tick();
            chk_out("hold", 1'b1, 2'd1, 32'hA5A5_0001);
        end
        out_ready = 1'b1;
        #1;
        chk_grant("unhold", 4'b1000, 32'hA5A5_0003);
        tick();
        chk_out("unhold", 1'b1, 2'd3, 32'hA5A5_0003);

        // All lanes valid, back-to-back from ptr=0.
        req_valid = 4'b1111;
        #1;
        chk_grant("rr0a", 4'b0001, 32'hA5A5_0000);
        tick();
        chk_out("rr0a", 1'b1, 2'd0, 32'hA5A5_0000);
        chk_grant("rr1a", 4'b0010, 32'hA5A5_0001);
        tick();
        chk_out("rr1a", 1'b1, 2'd1, 32'hA5A5_0001);
        chk_grant("rr2", 4'b0100, 32'hA5A5_0002);
        tick();
        chk_out("rr2", 1'b1, 2'd2, 32'hA5A5_0002);
        chk_grant("rr3", 4'b1000, 32'hA5A5_0003);
        tick();
        chk_out("rr3", 1'b1, 2'd3, 32'hA5A5_0003);
        chk_grant("rr0b", 4'b0001, 32'hA5A5_0000);
        tick();
        chk_out("rr0b", 1'b1, 2'd0, 32'hA5A5_0000);
        chk_grant("rr1b", 4'b0010, 32'hA5A5_0001);
        tick();
        chk_out("rr1b", 1'b1, 2'd1, 32'hA5A5_0001);

        // Async reset mid-cycle while FULL (ptr=2 before reset).
        #3;
        rst_n = 1'b0;
        #1;
        chk_out("arst", 1'b0, 2'd0, 32'h0);
        chk_grant("arst", 4'b0000, 32'h0);
        #1;
        rst_n = 1'b1;
        req_valid = 4'b0110;
        #1;
        chk_grant("post", 4'b0010, 32'hA5A5_0001);
        tick();
        chk_out("post", 1'b1, 2'd1, 32'hA5A5_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
